// File: rtl/mem_stage.sv
// mem_stage: EX/MEM -> MEM/WB data-memory stage.
// Issues dmem requests, formats load/store lanes, stalls while waiting.
package pkg;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef struct packed {
    logic       regf_we;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic        valid_s;
    mem_op_t     mem_ctrl_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] alu_out_s;
    logic [31:0] u_imm_s;
    logic        br_en_s;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic        valid_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] alu_out_s;
    logic [31:0] u_imm_s;
    logic        br_en_s;
    logic [31:0] mem_rdata_ext_s;
    logic [31:0] mem_addr_s;
    logic [3:0]  mem_rmask_s;
    logic [3:0]  mem_wmask_s;
    logic [31:0] mem_rdata_s;
    logic [31:0] mem_wdata_s;
  } mem_wb_stage_reg_t;
endpackage

module mem_stage
  import pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  ex_mem_stage_reg_t ex_mem_reg,
  output mem_wb_stage_reg_t mem_wb_reg,
  output logic              mem_stall,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              misalign_err,
  output logic              mem_timeout
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  mem_wb_stage_reg_t mem_wb_q, mem_wb_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [2:0]  f3;
  logic [1:0]  off;
  logic [4:0]  sh;
  logic        is_ld, is_st, is_mem;
  logic        sz_b, sz_h, sz_w;
  logic [3:0]  pat;
  logic        aligned, req, done;
  logic [31:0] rd_sh, ld_ext;

  always_comb begin
    f3     = ex_mem_reg.inst_s[14:12];
    off    = ex_mem_reg.alu_out_s[1:0];
    sh     = {off, 3'b000};
    is_ld  = ex_mem_reg.valid_s &&
             ex_mem_reg.mem_ctrl_s == MEM_LOAD;
    is_st  = ex_mem_reg.valid_s &&
             ex_mem_reg.mem_ctrl_s == MEM_STORE;
    is_mem = is_ld || is_st;
    sz_w   = f3[1];
    sz_h   = !f3[1] && f3[0];
    sz_b   = !f3[1] && !f3[0];
    pat     = 4'b0000;
    aligned = 1'b1;
    unique case (1'b1)
      sz_w: begin
        pat     = 4'b1111;
        aligned = off == 2'b00;
      end
      sz_h: begin
        pat     = 4'b0011 << off;
        aligned = !off[0];
      end
      sz_b: pat = 4'b0001 << off;
      default: ;
    endcase
    rd_sh  = dmem_rdata >> sh;
    ld_ext = rd_sh;
    unique case (1'b1)
      sz_w: ld_ext = rd_sh;
      sz_h: ld_ext = f3[2] ? {16'h0, rd_sh[15:0]}
                           : {{16{rd_sh[15]}}, rd_sh[15:0]};
      sz_b: ld_ext = f3[2] ? {24'h0, rd_sh[7:0]}
                           : {{24{rd_sh[7]}}, rd_sh[7:0]};
      default: ;
    endcase
  end

  // WAIT keeps requesting: upstream holds ex_mem_reg stable while stalled
  always_comb begin
    req = 1'b0;
    unique case (state_q)
      S_IDLE:  req = is_mem && aligned;
      S_WAIT:  req = 1'b1;
      default: req = 1'b0;
    endcase
    if (rst) req = 1'b0;
    done       = req && dmem_resp;
    mem_stall  = req && !dmem_resp;
    dmem_addr  = req ? {ex_mem_reg.alu_out_s[31:2], 2'b00} : 32'h0;
    dmem_rmask = (req && is_ld) ? pat : 4'h0;
    dmem_wmask = (req && is_st) ? pat : 4'h0;
    dmem_wdata = (req && is_st) ? ex_mem_reg.rs2_v_s << sh : 32'h0;
  end

  always_comb begin
    mem_wb_d                 = '0;
    mem_wb_d.inst_s          = ex_mem_reg.inst_s;
    mem_wb_d.pc_s            = ex_mem_reg.pc_s;
    mem_wb_d.pc_next_s       = ex_mem_reg.pc_next_s;
    mem_wb_d.order_s         = ex_mem_reg.order_s;
    mem_wb_d.valid_s         = ex_mem_reg.valid_s;
    mem_wb_d.wb_ctrl_s       = ex_mem_reg.wb_ctrl_s;
    mem_wb_d.rs1_v_s         = ex_mem_reg.rs1_v_s;
    mem_wb_d.rs2_v_s         = ex_mem_reg.rs2_v_s;
    mem_wb_d.rs1_s           = ex_mem_reg.rs1_s;
    mem_wb_d.rs2_s           = ex_mem_reg.rs2_s;
    mem_wb_d.rd_s            = ex_mem_reg.rd_s;
    mem_wb_d.alu_out_s       = ex_mem_reg.alu_out_s;
    mem_wb_d.u_imm_s         = ex_mem_reg.u_imm_s;
    mem_wb_d.br_en_s         = ex_mem_reg.br_en_s;
    mem_wb_d.mem_rdata_ext_s = (done && is_ld) ? ld_ext : 32'h0;
    mem_wb_d.mem_addr_s      = dmem_addr;
    mem_wb_d.mem_rmask_s     = dmem_rmask;
    mem_wb_d.mem_wmask_s     = dmem_wmask;
    mem_wb_d.mem_rdata_s     = (done && is_ld) ? dmem_rdata : 32'h0;
    mem_wb_d.mem_wdata_s     = dmem_wdata;
    mis_d = state_q == S_IDLE && is_mem && !aligned;
    if (mis_d) mem_wb_d.wb_ctrl_s.regf_we = 1'b0;
    if (mem_stall) begin
      mem_wb_d.valid_s           = 1'b0;
      mem_wb_d.wb_ctrl_s.regf_we = 1'b0;
      mis_d                      = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 32'h0;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: if (mem_stall) state_d = S_WAIT;
      S_WAIT: begin
        if (TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 >= TIMEOUT_CYCLES)
          to_d = 1'b1;
        if (dmem_resp) state_d = S_IDLE;
        else cnt_d = cnt_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mem_wb_q <= '0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      mem_wb_q <= mem_wb_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_wb_reg   = mem_wb_q;
  assign misalign_err = mis_q;
  assign mem_timeout  = to_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, directed corner sequences and random ops
// checked against a transaction-level model of the memory stage.
module tb_mem_stage;
  import pkg::*;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          wt;
    logic        vld;
    logic        we;
    logic        stray;
  } op_t;

  typedef struct {
    op_t         op;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [31:0] ext;
    logic        mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ex_mem_stage_reg_t ex = '0;
  logic [31:0] rdata = 32'h0;
  logic resp = 1'b0;

  mem_wb_stage_reg_t wb0, wb4;
  logic stall0, stall4, mis0, mis4, to0, to4;
  logic [31:0] addr0, addr4, wd0, wd4;
  logic [3:0] rm0, rm4, wm0, wm4;

  int n_checks = 0;
  int n_err = 0;
  longint order_n = 100;
  logic exp_to = 1'b0;
  logic [3:0] last_rm, last_wm;
  logic [31:0] last_wd, last_ext;
  logic last_mis;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ex_mem_reg(ex), .mem_wb_reg(wb0),
    .mem_stall(stall0), .dmem_addr(addr0), .dmem_rmask(rm0),
    .dmem_wmask(wm0), .dmem_wdata(wd0), .dmem_rdata(rdata),
    .dmem_resp(resp), .misalign_err(mis0), .mem_timeout(to0)
  );

  mem_stage #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .ex_mem_reg(ex), .mem_wb_reg(wb4),
    .mem_stall(stall4), .dmem_addr(addr4), .dmem_rmask(rm4),
    .dmem_wmask(wm4), .dmem_wdata(wd4), .dmem_rdata(rdata),
    .dmem_resp(resp), .misalign_err(mis4), .mem_timeout(to4)
  );

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic op_t mkop(logic [1:0] k, logic [2:0] f3,
                               logic [31:0] a, logic [31:0] r2,
                               logic [31:0] rd, int wt);
    op_t o;
    o.kind = k; o.f3 = f3; o.addr = a; o.rs2 = r2;
    o.rdata = rd; o.wt = wt; o.vld = 1'b1; o.we = 1'b1;
    o.stray = 1'b0;
    return o;
  endfunction

  // Byte-lane arithmetic model: size in bytes, offset, mask of size ones.
  function automatic void model(input op_t t,
      output logic [3:0] rm, output logic [3:0] wm,
      output logic [31:0] wd, output logic [31:0] ext,
      output logic mis, output logic iss);
    int sz, off;
    longint v, lim;
    logic [3:0] m;
    rm = 0; wm = 0; wd = 0; ext = 0; mis = 0; iss = 0;
    if (!t.vld || t.kind == 2'd0) return;
    sz  = t.f3[1] ? 4 : (t.f3[0] ? 2 : 1);
    off = int'(t.addr % 4);
    if (off % sz != 0) begin
      mis = 1;
      return;
    end
    iss = 1;
    m = 4'(((1 << sz) - 1) << off);
    if (t.kind == 2'd1) begin
      rm  = m;
      lim = 64'd1 << (8 * sz);
      v   = longint'(t.rdata >> (8 * off)) % lim;
      if (!t.f3[2] && sz < 4 && v >= lim / 2) v = v - lim;
      ext = 32'(v);
    end else begin
      wm = m;
      wd = t.rs2 << (8 * off);
    end
  endfunction

  function automatic ex_mem_stage_reg_t mk_ex(op_t t, longint ord);
    ex_mem_stage_reg_t e;
    e = '0;
    e.inst_s = {17'h0, t.f3, 12'h003};
    e.pc_s = 32'(ord * 4);
    e.pc_next_s = 32'(ord * 4 + 4);
    e.order_s = 64'(ord);
    e.valid_s = t.vld;
    e.mem_ctrl_s = mem_op_t'(t.kind);
    e.wb_ctrl_s.regf_we = t.we;
    e.rs2_v_s = t.rs2;
    e.rd_s = 5'd5;
    e.alu_out_s = t.addr;
    return e;
  endfunction

  task automatic run_op(input op_t t);
    logic [3:0] rm, wm;
    logic [31:0] wd, ext;
    logic mis, iss, stl;
    int ncyc;
    model(t, rm, wm, wd, ext, mis, iss);
    ex = mk_ex(t, order_n);
    ncyc = iss ? t.wt + 1 : 1;
    for (int c = 0; c < ncyc; c++) begin
      resp  = iss ? (c == t.wt) : t.stray;
      rdata = resp ? t.rdata : $urandom;
      stl   = iss && c < t.wt;
      #2;
      chk("stall", stall0, stl);
      chk("stall_t4", stall4, stl);
      chk("rmask", rm0, rm);
      chk("wmask", wm0, wm);
      chk("wdata", wd0, wd);
      if (iss) chk("addr", addr0, {t.addr[31:2], 2'b00});
      last_rm = rm0; last_wm = wm0; last_wd = wd0;
      @(posedge clk); #1;
      if (iss && c >= 4) exp_to = 1'b1;
      chk("timeout4", to4, exp_to);
      chk("timeout0", to0, 0);
      if (stl) begin
        chk("bubble_valid", wb0.valid_s, 0);
        chk("bubble_we", wb0.wb_ctrl_s.regf_we, 0);
        chk("bubble_mis", mis0, 0);
      end else begin
        chk("valid", wb0.valid_s, t.vld);
        chk("valid_t4", wb4.valid_s, t.vld);
        chk("order", wb0.order_s, order_n);
        chk("we", wb0.wb_ctrl_s.regf_we, t.we && !mis);
        chk("misalign", mis0, mis);
        chk("rdata_ext", wb0.mem_rdata_ext_s, ext);
        chk("wb_rmask", wb0.mem_rmask_s, rm);
        chk("wb_wmask", wb0.mem_wmask_s, wm);
        last_ext = wb0.mem_rdata_ext_s;
        last_mis = mis0;
      end
    end
    resp = 1'b0;
    order_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1; ex = '0; resp = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_to = 1'b0;
  endtask

  vec_t tbl[14];
  op_t o;
  logic [2:0] ldf3[5];

  initial begin
    ldf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    tbl[0]  = '{mkop(1, 3'd0, 32'h1003, 0, 32'h80AABBCC, 2),
                4'b1000, 4'b0, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[1]  = '{mkop(2, 3'd1, 32'h2002, 32'h1234ABCD, 0, 0),
                4'b0, 4'b1100, 32'hABCD0000, 32'h0, 1'b0};
    tbl[2]  = '{mkop(1, 3'd5, 32'h3001, 0, 32'h11223344, 0),
                4'b0, 4'b0, 32'h0, 32'h0, 1'b1};
    tbl[3]  = '{mkop(1, 3'd2, 32'h4000, 0, 32'hDEADBEEF, 0),
                4'b1111, 4'b0, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{mkop(1, 3'd4, 32'h1001, 0, 32'h80AABBCC, 0),
                4'b0010, 4'b0, 32'h0, 32'h000000BB, 1'b0};
    tbl[5]  = '{mkop(1, 3'd1, 32'h1002, 0, 32'h80AABBCC, 1),
                4'b1100, 4'b0, 32'h0, 32'hFFFF80AA, 1'b0};
    tbl[6]  = '{mkop(1, 3'd5, 32'h1000, 0, 32'h80AABBCC, 0),
                4'b0011, 4'b0, 32'h0, 32'h0000BBCC, 1'b0};
    tbl[7]  = '{mkop(2, 3'd0, 32'h5003, 32'h000000A5, 0, 0),
                4'b0, 4'b1000, 32'hA5000000, 32'h0, 1'b0};
    tbl[8]  = '{mkop(2, 3'd2, 32'h6000, 32'hCAFEF00D, 0, 1),
                4'b0, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
    tbl[9]  = '{mkop(2, 3'd2, 32'h6002, 32'hCAFEF00D, 0, 0),
                4'b0, 4'b0, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{mkop(1, 3'd2, 32'h7001, 0, 32'h12345678, 0),
                4'b0, 4'b0, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{mkop(0, 3'd0, 32'h8003, 32'h55, 0, 0),
                4'b0, 4'b0, 32'h0, 32'h0, 1'b0};
    tbl[12] = '{mkop(1, 3'd0, 32'h1000, 0, 32'h0000007F, 0),
                4'b0001, 4'b0, 32'h0, 32'h0000007F, 1'b0};
    tbl[13] = '{mkop(2, 3'd1, 32'h2003, 32'hFFFF, 0, 0),
                4'b0, 4'b0, 32'h0, 32'h0, 1'b1};

    do_reset();
    chk("rst_valid", wb0.valid_s, 0);
    chk("rst_order", wb0.order_s, 0);
    chk("rst_stall", stall0, 0);
    chk("rst_rmask", rm0, 0);
    chk("rst_wmask", wm0, 0);
    chk("rst_mis", mis0, 0);
    chk("rst_to", to4, 0);

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op);
      chk($sformatf("tbl%0d_rmask", i), last_rm, tbl[i].rm);
      chk($sformatf("tbl%0d_wmask", i), last_wm, tbl[i].wm);
      chk($sformatf("tbl%0d_wdata", i), last_wd, tbl[i].wd);
      chk($sformatf("tbl%0d_ext", i), last_ext, tbl[i].ext);
      chk($sformatf("tbl%0d_mis", i), last_mis, tbl[i].mis);
    end

    // LW, ADD, LW back to back, one wait cycle per load
    run_op(mkop(1, 3'd2, 32'h9000, 0, 32'hA1A2A3A4, 1));
    run_op(mkop(0, 3'd0, 32'h0, 0, 0, 0));
    run_op(mkop(1, 3'd2, 32'h9004, 0, 32'hB1B2B3B4, 1));

    // stray response with no request
    o = mkop(0, 3'd0, 32'h0, 0, 32'hFFFFFFFF, 0);
    o.stray = 1'b1;
    run_op(o);
    o = mkop(1, 3'd2, 32'h0, 0, 32'hFFFFFFFF, 0);
    o.vld = 1'b0; o.stray = 1'b1;
    run_op(o);

    // watchdog: six wait cycles on a word load
    run_op(mkop(1, 3'd2, 32'hA000, 0, 32'h600D600D, 6));
    chk("to_sticky_after_done", to4, 1);
    run_op(mkop(0, 3'd0, 32'h0, 0, 0, 0));
    chk("to_sticky_later", to4, 1);

    // reset while waiting, then a stray response
    ex = mk_ex(mkop(1, 3'd2, 32'hB000, 0, 0, 0), order_n);
    resp = 1'b0;
    #2;
    chk("pre_rst_stall", stall0, 1);
    @(posedge clk); #1;
    chk("wait_rmask", rm0, 4'b1111);
    rst = 1'b1; ex = '0;
    @(posedge clk); #1;
    rst = 1'b0; resp = 1'b1; rdata = 32'hDEAD0000;
    exp_to = 1'b0;
    #1;
    chk("rst_wait_rmask", rm0, 0);
    chk("rst_wait_stall", stall0, 0);
    chk("rst_wait_valid", wb0.valid_s, 0);
    chk("rst_wait_to", to4, 0);
    @(posedge clk); #1;
    chk("stray_valid", wb0.valid_s, 0);
    chk("stray_ext", wb0.mem_rdata_ext_s, 0);
    chk("stray_mis", mis0, 0);
    resp = 1'b0;

    for (int i = 0; i < 250; i++) begin
      o.kind  = 2'($urandom_range(0, 2));
      o.f3    = (o.kind == 2'd1) ? ldf3[$urandom_range(0, 4)]
                                 : 3'($urandom_range(0, 2));
      o.addr  = $urandom;
      o.rs2   = $urandom;
      o.rdata = $urandom;
      o.wt    = $urandom_range(0, 5);
      o.vld   = $urandom_range(0, 7) != 0;
      o.we    = 1'($urandom_range(0, 1));
      o.stray = 1'($urandom_range(0, 1));
      run_op(o);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end
endmodule
